// File: rtl/uart_tx_stream.sv
// Free-running 8N1 UART beacon: serialises `data` forever as idle, start, 8 data bits LSB-first, stop.
// Latency: data sampled at the end of the idle bit; tx follows each state decision by one clk edge.
// Backpressure: none; there is no handshake and the frame cadence is fixed at 11 bit periods.
module uart_tx_stream #(
  parameter int BAUD = 9600,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  output logic       tx
);

  localparam int CLKS_PER_BIT = F / BAUD;
  // Guard keeps the counter at least one bit wide even when the check below fires.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_divider
      $error("uart_tx_stream: F/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_DATA  = 2'b01,
    S_STOP  = 2'b10,
    S_IDLE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            period_end;

  // State register; reset parks the line high in IDLE, abandoning any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state, bit timing and line level; tx is derived from the current state so every
  // transition reaches the pin exactly one edge after it is decided.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    period_end = (cnt_q == CNT_LAST);
    cnt_d      = period_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (period_end) begin
          shift_d = data;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (period_end) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[bit_q];
        if (period_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (period_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

  localparam int A_CPB = 10;    // F=100, BAUD=10
  localparam int B_CPB = 4;     // F=40,  BAUD=10
  localparam int C_CPB = 5208;  // default parameters

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rst_c;
  logic [7:0] data_a, data_b, data_c;
  logic       tx_a, tx_b, tx_c;

  int tests = 0;
  int fails = 0;
  int a_edge = 0;
  int c_edge = 0;

  always #5 clk = ~clk;

  uart_tx_stream #(.BAUD(10), .F(100)) u_a (.clk(clk), .rst(rst_a), .data(data_a), .tx(tx_a));
  uart_tx_stream #(.BAUD(10), .F(40))  u_b (.clk(clk), .rst(rst_b), .data(data_b), .tx(tx_b));
  uart_tx_stream                       u_c (.clk(clk), .rst(rst_c), .data(data_c), .tx(tx_c));

  // Expected line level of bit slot j (0 idle, 1 start, 2..9 data LSB first, 10 stop).
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0 || j == 10) return 1'b1;
    if (j == 1) return 1'b0;
    return d[j-2];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after rising edge number e counted from reset release.
  task automatic goto_edge(inout int cur, input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  // Bit slot j of frame f occupies the cycles after edges base+1 .. base+CPB.
  task automatic a_check_bit(input int f, input int j, input logic [7:0] d);
    int base;
    base = f * 11 * A_CPB + j * A_CPB;
    goto_edge(a_edge, base + 1);
    chk($sformatf("a_f%0d_slot%0d_first", f, j), tx_a, frame_bit(d, j));
    goto_edge(a_edge, base + A_CPB);
    chk($sformatf("a_f%0d_slot%0d_last", f, j), tx_a, frame_bit(d, j));
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    data_a = 8'hAA; data_b = 8'h01; data_c = 8'hAA;

    // Reset hold: line stays high on every instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold_a_%0d", i), tx_a, 1'b1);
      chk($sformatf("reset_hold_b_%0d", i), tx_b, 1'b1);
    end

    // Three back-to-back 0xAA frames from reset release.
    @(negedge clk);
    rst_a  = 1'b1;
    a_edge = 0;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 11; j++) a_check_bit(f, j, 8'hAA);
    end

    // 0x0F captured for frame 3, changed to 0xF0 during its data bits.
    data_a = 8'h0F;
    for (int j = 0; j < 11; j++) begin
      if (j == 6) data_a = 8'hF0;
      a_check_bit(3, j, 8'h0F);
    end
    for (int j = 0; j < 11; j++) a_check_bit(4, j, 8'hF0);

    // Asynchronous reset in the middle of data bit 3 (a 0 bit of 0xF0).
    goto_edge(a_edge, 5 * 11 * A_CPB + 5 * A_CPB + 3);
    chk("a_before_mid_reset", tx_a, 1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_async_reset_immediate", tx_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("a_reset_held_%0d", i), tx_a, 1'b1);
    end
    @(negedge clk);
    rst_a  = 1'b1;
    a_edge = 0;
    for (int j = 0; j < 11; j++) a_check_bit(0, j, 8'hF0);

    // Small divider: every cycle of one 0x01 frame checked.
    @(negedge clk);
    rst_b = 1'b1;
    for (int e = 1; e <= 11 * B_CPB; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b_cycle_%0d", e), tx_b, frame_bit(8'h01, (e - 1) / B_CPB));
    end
    // Next frame starts with a full idle period then the start bit.
    for (int e = 11 * B_CPB + 1; e <= 13 * B_CPB; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2_cycle_%0d", e), tx_b, frame_bit(8'h01, (e - 1) / B_CPB - 11));
    end

    // Default divider: bit boundaries land at multiples of 5208 cycles.
    @(negedge clk);
    rst_c  = 1'b1;
    c_edge = 0;
    goto_edge(c_edge, C_CPB);
    chk("c_idle_last", tx_c, 1'b1);
    goto_edge(c_edge, C_CPB + 1);
    chk("c_start_first", tx_c, 1'b0);
    goto_edge(c_edge, 3 * C_CPB);
    chk("c_bit0_last", tx_c, 1'b0);
    goto_edge(c_edge, 3 * C_CPB + 1);
    chk("c_bit1_first", tx_c, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Free-running 8N1 UART transmitter.
- Repeatedly serialises the 8-bit `data` input onto `tx`.
- Each frame is one idle bit, one start bit, eight data bits LSB-first, and one stop bit.
- There is no handshake. Used as a fixed-pattern or status beacon on a board serial line, driven from the system clock.

Parameters:
- BAUD, 9600, serial bit rate in bits/s.
- F, 50000000, clk frequency in Hz.
- CLKS_PER_BIT (localparam), F/BAUD with integer (floor) division, clk cycles per bit period. Default = 5208.
- Required: CLKS_PER_BIT >= 2. Elaboration-time check, otherwise error.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  8  byte to transmit; sampled at frame start.
- tx  output  1  serial line; idles high; driven directly from a flip-flop.

Behaviour:
- Reset:
  - Asserting rst (low) immediately forces tx=1, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - Applies even mid-frame; there is no completion of a partial frame.
- After rst deasserts, the machine starts in IDLE on the first rising clk edge.
- Timing base:
  - A cycle counter counts 0..CLKS_PER_BIT-1.
  - Every state/bit advance happens on the edge where the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every bit, including idle, therefore lasts exactly CLKS_PER_BIT clk cycles.
- State encoding is 2 bits: START=00, DATA=01, STOP=10, IDLE=11.
- IDLE:
  - tx=1 for one bit period.
  - On period end: latch data into shift register, go to START.
- START:
  - tx=0 for one bit period.
  - On period end: go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[bit index] for one bit period each, index 0..7 (LSB first).
  - After index 7 completes, go to STOP.
  - The bit index is 3 bits and does not wrap past 7 within a frame.
- STOP:
  - tx=1 for one bit period.
  - On period end: go to IDLE.
- Frame length is 11 bit periods (IDLE+START+8 DATA+STOP). The pattern repeats indefinitely.
- Data capture:
  - data is sampled only on the IDLE→START transition.
  - Changes to data during START/DATA/STOP do not affect the current frame; they appear in the next frame.
- tx is registered: a state change becomes visible on tx one clk edge after the decision edge, uniformly for all transitions. The measured bit widths are thus exactly CLKS_PER_BIT cycles.
- No glitches on tx; it is updated only on clk edges or by asynchronous reset.
- Counter widths:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits.
  - No arithmetic overflow is permitted; compare for equality with CLKS_PER_BIT-1.

Test Plan:
- Reset hold: rst=0 for several cycles with data=8'hAA → tx=1 throughout; no transitions.
- Single frame 0xAA, default params:
  - Release rst.
  - tx=1 for 5208 cycles, then 0 (start), then bits 0,1,0,1,0,1,0,1, each 5208 cycles, then 1 (stop) for 5208 cycles.
- Continuous repeat: hold data=8'hAA for 3 frames → identical 11-bit-period pattern repeats with period 11×5208 = 57288 cycles.
- Data change mid-frame:
  - data=8'h0F at frame start, changed to 8'hF0 during DATA.
  - Current frame sends 1,1,1,1,0,0,0,0.
  - Next frame sends 0,0,0,0,1,1,1,1.
- Reset mid-frame: pull rst low during data bit 3 → tx=1 immediately (asynchronous). After release, a full idle period precedes a new start bit.
- Small divider: F=40, BAUD=10 (CLKS_PER_BIT=4), data=8'h01 → start bit 4 cycles low, bit0 high 4 cycles, bits1-7 low 28 cycles, stop high 4 cycles.
